// File: rtl/mul_issue_if.sv
// mul_issue_if: groups the issue, multiplier and writeback handshakes of mul_issue.
// The slave modport is the controller's view; master is the surrounding pipeline/multiplier.
interface mul_issue_if #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic              in_w;
  logic [XLEN-1:0]   in_rs1;
  logic [XLEN-1:0]   in_rs2;
  logic [TAGW-1:0]   in_tag;
  logic              kill;
  logic              mul_valid;
  logic              mul_ready;
  logic              flush;
  logic              mulw;
  logic [1:0]        mul_signed;
  logic [XLEN-1:0]   multiplicand;
  logic [XLEN-1:0]   multiplier;
  logic              out_valid;
  logic [XLEN-1:0]   result_hi;
  logic [XLEN-1:0]   result_lo;
  logic              res_valid;
  logic              res_ready;
  logic [XLEN-1:0]   res_data;
  logic [TAGW-1:0]   res_tag;

  modport slave (
    input  in_valid, in_op, in_w, in_rs1, in_rs2, in_tag, kill,
    output in_ready,
    output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier,
    input  mul_ready,
    input  out_valid, result_hi, result_lo,
    output res_valid, res_data, res_tag,
    input  res_ready
  );

  modport master (
    output in_valid, in_op, in_w, in_rs1, in_rs2, in_tag, kill,
    input  in_ready,
    input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier,
    output mul_ready,
    output out_valid, result_hi, result_lo,
    input  res_valid, res_data, res_tag,
    output res_ready
  );
endinterface

// File: rtl/mul_issue.sv
// mul_issue: requester-side controller for the multiplier handshake.
// Accepts one RV64M multiply at a time, issues it, captures and selects the
// architectural result and hands it to writeback with its tag.
// Optional feature: define MUL_ISSUE_ZERO_BYPASS_EN to short-circuit ops with a
// zero operand straight to a zero result without touching the multiplier.
module mul_issue #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input logic       clock,
  input logic       reset,
  mul_issue_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_fire;
  logic              w_kill_busy;
  logic              w_capture;
  logic              w_release;
  logic              w_bypass;
  logic              w_zero;

  logic [1:0]        r_op;
  logic              r_w;
  logic              r_mul_valid;
  logic              r_flush;
  logic              r_mulw;
  logic [1:0]        r_mul_signed;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic              r_res_valid;
  logic [XLEN-1:0]   r_res_data;
  logic [TAGW-1:0]   r_res_tag;

  // Signedness control; word ops (legal or not) are unsigned on the low half.
  function automatic logic [1:0] f_signed_ctl(input logic [1:0] op, input logic w);
    logic [1:0] v;
    if (w) begin
      v = 2'b00;
    end else begin
      case (op)
        2'b00:   v = 2'b11;
        2'b01:   v = 2'b11;
        2'b10:   v = 2'b10;
        2'b11:   v = 2'b00;
        default: v = 2'b00;
      endcase
    end
    return v;
  endfunction

  // Architectural result: low half for MUL, sign-extended low word for MULW, else high half.
  function automatic logic [XLEN-1:0] f_select(input logic [1:0] op, input logic w,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [XLEN-1:0] v;
    if (w) begin
      v = {{(XLEN-32){lo[31]}}, lo[31:0]};
    end else if (op == 2'b00) begin
      v = lo;
    end else begin
      v = hi;
    end
    return v;
  endfunction

`ifdef MUL_ISSUE_ZERO_BYPASS_EN
  assign w_zero = (bus.in_rs1 == {XLEN{1'b0}}) || (bus.in_rs2 == {XLEN{1'b0}});
`else
  assign w_zero = 1'b0;
`endif

  assign bus.in_ready     = (r_state == S_IDLE);
  assign bus.mul_valid    = r_mul_valid;
  assign bus.flush        = r_flush;
  assign bus.mulw         = r_mulw;
  assign bus.mul_signed   = r_mul_signed;
  assign bus.multiplicand = r_mcand;
  assign bus.multiplier   = r_mplier;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.res_tag      = r_res_tag;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and transition strobes; kill wins over every other transition.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_fire      = 1'b0;
    w_kill_busy = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_bypass    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.kill && bus.in_valid) begin
          w_accept = 1'b1;
          if (w_zero) begin
            w_bypass = 1'b1;
            w_next   = S_HOLD;
          end else begin
            w_next   = S_ISSUE;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (bus.kill) begin
          w_kill_busy = 1'b1;
          w_next      = S_IDLE;
        end else if (bus.mul_ready) begin
          w_fire = 1'b1;
          w_next = S_WAIT;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (bus.kill) begin
          w_kill_busy = 1'b1;
          w_next      = S_IDLE;
        end else if (bus.out_valid) begin
          w_capture = 1'b1;
          w_next    = S_HOLD;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bus.kill || bus.res_ready) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_next = S_HOLD;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Registered request, flush and result outputs plus the latched op.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op         <= 2'b00;
      r_w          <= 1'b0;
      r_mul_valid  <= 1'b0;
      r_flush      <= 1'b0;
      r_mulw       <= 1'b0;
      r_mul_signed <= 2'b00;
      r_mcand      <= {XLEN{1'b0}};
      r_mplier     <= {XLEN{1'b0}};
      r_res_valid  <= 1'b0;
      r_res_data   <= {XLEN{1'b0}};
      r_res_tag    <= {TAGW{1'b0}};
    end else begin
      r_flush <= w_kill_busy;
      if (w_accept) begin
        r_op         <= bus.in_w ? 2'b00 : bus.in_op;
        r_w          <= bus.in_w;
        r_mulw       <= bus.in_w;
        r_mul_signed <= f_signed_ctl(bus.in_op, bus.in_w);
        r_mcand      <= bus.in_rs1;
        r_mplier     <= bus.in_rs2;
        r_res_tag    <= bus.in_tag;
        r_mul_valid  <= ~w_bypass;
        if (w_bypass) begin
          r_res_valid <= 1'b1;
          r_res_data  <= {XLEN{1'b0}};
        end
      end else if (w_fire || w_kill_busy) begin
        r_mul_valid <= 1'b0;
      end
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= f_select(r_op, r_w, bus.result_hi, bus.result_lo);
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue: randomized self-checking bench for mul_issue with a behavioural
// reference for the RV64M results and a simple multiplier stub.
module tb_mul_issue;
  localparam int XLEN = 64;
  localparam int TAGW = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mul_issue_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();
  mul_issue #(.XLEN(XLEN), .TAGW(TAGW)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: RV64M semantics from the operand values, by op name.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, ua, sb, ub;
    logic [129:0] p;
    sa = {{66{a[63]}}, a};
    ua = {66'd0, a};
    sb = {{66{b[63]}}, b};
    ub = {66'd0, b};
    if (w) begin
      p = ua * ub;
      return {{32{p[31]}}, p[31:0]};
    end
    case (op)
      2'b00:   begin p = ua * ub; return p[63:0];   end
      2'b01:   begin p = sa * sb; return p[127:64]; end
      2'b10:   begin p = sa * ub; return p[127:64]; end
      default: begin p = ua * ub; return p[127:64]; end
    endcase
  endfunction

  function automatic logic [1:0] ref_sig(input logic [1:0] op, input logic w);
    if (w) return 2'b00;
    case (op)
      2'b10:   return 2'b10;
      2'b11:   return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  // Multiplier stub: full 128-bit product under the requested signedness.
  function automatic logic [127:0] stub_prod(input logic [1:0] sig, input logic [63:0] a,
                                             input logic [63:0] b);
    logic signed [129:0] ea, eb, p;
    ea = sig[1] ? {{66{a[63]}}, a} : {66'd0, a};
    eb = sig[0] ? {{66{b[63]}}, b} : {66'd0, b};
    p = ea * eb;
    return p[127:0];
  endfunction

  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input int mrdy_wait,
                        input int lat, input int hold_wait, input bit end_kill);
    logic [63:0]  exp;
    logic [1:0]   esig;
    logic [127:0] prod;
    bit           byp;
    exp  = ref_res(op, w, a, b);
    esig = ref_sig(op, w);
    byp  = 1'b0;
`ifdef MUL_ISSUE_ZERO_BYPASS_EN
    byp = (a == 64'd0) || (b == 64'd0);
    if (byp) exp = 64'd0;
`endif
    check_val("idle_in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_w = w;
    bus.in_rs1 = a; bus.in_rs2 = b; bus.in_tag = tag;
    tick();
    bus.in_valid = 1'b0;
    bus.in_rs1 = {$urandom, $urandom}; bus.in_rs2 = {$urandom, $urandom};
    check_val("in_ready_busy", bus.in_ready, 1'b0);
    if (byp) begin
      check_val("byp_mul_valid", bus.mul_valid, 1'b0);
    end else begin
      check_val("mul_valid", bus.mul_valid, 1'b1);
      check_val("mulw", bus.mulw, w);
      check_val("mul_signed", bus.mul_signed, esig);
      check_val("multiplicand", bus.multiplicand, a);
      check_val("multiplier", bus.multiplier, b);
      for (int i = 0; i < mrdy_wait; i++) begin
        bus.mul_ready = 1'b0;
        tick();
        check_val("bp_mul_valid", bus.mul_valid, 1'b1);
        check_val("bp_mcand", bus.multiplicand, a);
        check_val("bp_mplier", bus.multiplier, b);
        check_val("bp_signed", bus.mul_signed, esig);
      end
      bus.mul_ready = 1'b1;
      tick();
      bus.mul_ready = 1'b0;
      check_val("mul_valid_drop", bus.mul_valid, 1'b0);
      prod = stub_prod(bus.mul_signed, bus.multiplicand, bus.multiplier);
      for (int i = 0; i < lat; i++) begin
        tick();
        check_val("wait_res_valid", bus.res_valid, 1'b0);
      end
      bus.out_valid = 1'b1;
      bus.result_hi = prod[127:64];
      bus.result_lo = prod[63:0];
      tick();
      bus.out_valid = 1'b0;
      bus.result_hi = {$urandom, $urandom};
      bus.result_lo = {$urandom, $urandom};
    end
    check_val("res_valid", bus.res_valid, 1'b1);
    check_val("res_data", bus.res_data, exp);
    check_val("res_tag", bus.res_tag, tag);
    for (int i = 0; i < hold_wait; i++) begin
      bus.res_ready = 1'b0;
      tick();
      check_val("hold_valid", bus.res_valid, 1'b1);
      check_val("hold_data", bus.res_data, exp);
      check_val("hold_tag", bus.res_tag, tag);
    end
    if (end_kill) bus.kill = 1'b1;
    else bus.res_ready = 1'b1;
    tick();
    bus.kill = 1'b0;
    bus.res_ready = 1'b0;
    check_val("release_valid", bus.res_valid, 1'b0);
    check_val("release_ready", bus.in_ready, 1'b1);
    check_val("release_flush", bus.flush, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_w = 1'b0;
    bus.in_rs1 = 64'd0; bus.in_rs2 = 64'd0; bus.in_tag = 5'd0;
    bus.kill = 1'b0; bus.mul_ready = 1'b0; bus.out_valid = 1'b0;
    bus.result_hi = 64'd0; bus.result_lo = 64'd0; bus.res_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_in_ready", bus.in_ready, 1'b1);
    check_val("rst_mul_valid", bus.mul_valid, 1'b0);
    check_val("rst_flush", bus.flush, 1'b0);
    check_val("rst_res_valid", bus.res_valid, 1'b0);
    check_val("rst_mulw", bus.mulw, 1'b0);
    check_val("rst_signed", bus.mul_signed, 2'b00);
    check_val("rst_mcand", bus.multiplicand, 64'd0);
    check_val("rst_mplier", bus.multiplier, 64'd0);
    check_val("rst_res_data", bus.res_data, 64'd0);
    check_val("rst_res_tag", bus.res_tag, 5'd0);
    reset = 1'b1;
    tick();

    // Directed ops from the plan.
    run_op(2'b00, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd3, 0, 1, 0, 1'b0);
    run_op(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 0, 0, 0, 1'b0);
    run_op(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1, 2, 0, 1'b0);
    run_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd11, 0, 0, 1, 1'b0);
    run_op(2'b00, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd12, 4, 3, 0, 1'b0);
    run_op(2'b00, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h3, 5'd21, 0, 0, 3, 1'b1);
    run_op(2'b11, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, 5'd4, 0, 0, 0, 1'b0);
    run_op(2'b00, 1'b0, 64'd0, 64'd5, 5'd15, 0, 1, 0, 1'b0);

    // Kill while waiting for the multiplier, then a stale response.
    bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_w = 1'b0;
    bus.in_rs1 = 64'd6; bus.in_rs2 = 64'd7; bus.in_tag = 5'd1;
    tick();
    bus.in_valid = 1'b0;
    bus.mul_ready = 1'b1;
    tick();
    bus.mul_ready = 1'b0;
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    check_val("kw_flush", bus.flush, 1'b1);
    check_val("kw_in_ready", bus.in_ready, 1'b1);
    check_val("kw_mul_valid", bus.mul_valid, 1'b0);
    bus.out_valid = 1'b1; bus.result_lo = 64'd42; bus.result_hi = 64'd0;
    tick();
    bus.out_valid = 1'b0;
    check_val("kw_flush_once", bus.flush, 1'b0);
    check_val("kw_no_res", bus.res_valid, 1'b0);
    tick();
    check_val("kw_no_res2", bus.res_valid, 1'b0);
    check_val("kw_idle", bus.in_ready, 1'b1);

    // Kill while the request is still pending.
    bus.in_valid = 1'b1; bus.in_rs1 = 64'd3; bus.in_rs2 = 64'd3;
    tick();
    bus.in_valid = 1'b0;
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    check_val("ki_flush", bus.flush, 1'b1);
    check_val("ki_mul_valid", bus.mul_valid, 1'b0);
    check_val("ki_in_ready", bus.in_ready, 1'b1);
    tick();
    check_val("ki_flush_once", bus.flush, 1'b0);

    // Kill in IDLE blocks acceptance.
    bus.in_valid = 1'b1; bus.kill = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.kill = 1'b0;
    check_val("kidle_mul_valid", bus.mul_valid, 1'b0);
    check_val("kidle_in_ready", bus.in_ready, 1'b1);
    check_val("kidle_flush", bus.flush, 1'b0);

    // Reset mid-operation clears everything at once.
    bus.in_valid = 1'b1; bus.in_rs1 = 64'd9; bus.in_rs2 = 64'd9;
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_val("mrst_mul_valid", bus.mul_valid, 1'b0);
    check_val("mrst_in_ready", bus.in_ready, 1'b1);
    check_val("mrst_mcand", bus.multiplicand, 64'd0);
    check_val("mrst_flush", bus.flush, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // Randomized ops, including illegal word encodings and corner operands.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic        w;
      logic [63:0] a, b;
      op = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 3) == 0);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       a = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       b = 64'h8000_0000_0000_0000;
        2:       a = 64'd0;
        3:       b = 64'h0000_0000_8000_0000;
        default: a = a;
      endcase
      run_op(op, w, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
